// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one load/store request at a time
// over valid/ready, with the result returned after a fixed wait-state latency.
// Handles RV32I byte/half/word accesses and flags misaligned, illegal-funct3
// and out-of-range requests.
module data_mem_responder #(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned WaitCycles = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned CntW = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam int unsigned IdxW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WaitCycles);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [31:0]     addr_q, wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            accept, commit;

  logic [31:0]     mem_q [DepthWords];

  logic [IdxW-1:0] idx;
  logic            out_of_range, misaligned, bad_f3, access_err;
  logic [31:0]     rd_word, rd_shift, load_data, wlane;
  logic [3:0]      be;

  // Decode the latched request: error detection, load extraction, store lanes.
  always_comb begin
    idx          = addr_q[IdxW+1:2];
    out_of_range = ({2'b00, addr_q[31:2]} >= DepthWords);
    misaligned   = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    // Stores allow only B/H/W; loads additionally allow BU/HU.
    bad_f3       = we_q ? (f3_q[2] || (f3_q[1:0] == 2'b11))
                        : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
    access_err   = out_of_range || misaligned || bad_f3;

    rd_word  = mem_q[idx];
    rd_shift = rd_word >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'h000000, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_data = {16'h0000, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase

    be    = 4'b0000;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Next-state logic: accept in idle, count down wait states, commit, hand off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = StWait;
          // A zero wait still spends one cycle in StWait, so the response
          // always appears WaitCycles+1 edges after accept.
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = StResp;
          err_d   = access_err;
          rdata_d = (access_err || we_q) ? 32'h0 : load_data;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture the request fields on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Array write on the commit edge; reset forces state to idle, so an
  // aborted store never reaches here.
  always_ff @(posedge clk) begin
    if (commit && we_q && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule
